// File: rtl/digit_recognizer_pkg.sv
// Shared constants, command codes and the FSM state type for the digit recognizer.
package digit_recognizer_pkg;

  localparam int NUM_PIXELS  = 144;
  localparam int NUM_CLASSES = 10;
  localparam int PIXEL_W     = 4;

  localparam logic [7:0]  CMD_LOAD  = 8'h00;
  localparam logic [7:0]  CMD_RUN   = 8'hFF;
  localparam logic [15:0] BIAS_BASE = 16'(NUM_CLASSES * NUM_PIXELS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LOADED,
    ST_COMPUTE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/digit_recognizer_spi_byte_slave.sv
// SPI byte slave: samples SCK/SS/MOSI into clk, assembles LSB-first bytes and
// shifts the latched status byte out on MISO.
module spi_byte_slave (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sck,
  input  logic       ss,
  input  logic       mosi,
  input  logic [7:0] status,
  output logic       miso,
  output logic       rx_valid,
  output logic [7:0] rx_byte
);

  logic [1:0] sck_sync, ss_sync, mosi_sync;
  logic       sck_d, ss_d;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift, tx_shift;
  logic       sck_rise, sck_fall, ss_fall, ss_hi;

  assign ss_hi    = ss_sync[1];
  assign sck_rise = sck_sync[1] & ~sck_d;
  assign sck_fall = ~sck_sync[1] & sck_d;
  assign ss_fall  = ss_d & ~ss_sync[1];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sck_sync  <= 2'b00;
      ss_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sck_d     <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[0], sck};
      ss_sync   <= {ss_sync[0], ss};
      mosi_sync <= {mosi_sync[0], mosi};
      sck_d     <= sck_sync[1];
      ss_d      <= ss_sync[1];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (ss_hi) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        rx_shift <= {mosi_sync[1], rx_shift[7:1]};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_valid <= 1'b1;
          rx_byte  <= {mosi_sync[1], rx_shift[7:1]};
        end
      end
    end
  end

  // Status is captured once per frame so a byte in flight never changes mid-shift.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_shift <= '0;
      miso     <= 1'b0;
    end else if (ss_hi) begin
      miso <= 1'b0;
    end else if (ss_fall) begin
      miso     <= status[0];
      tx_shift <= {1'b0, status[7:1]};
    end else if (sck_fall) begin
      miso     <= tx_shift[0];
      tx_shift <= {1'b0, tx_shift[7:1]};
    end
  end

endmodule

// File: rtl/digit_recognizer.sv
// Digit recognizer: SPI-loaded 12x12 image, linear classifier with weights read
// from an external flash. Optional macro SCORE_BIAS_EN seeds each class score
// with a bias word read from flash.
module digit_recognizer #(
  parameter int NUM_PIXELS  = digit_recognizer_pkg::NUM_PIXELS,
  parameter int NUM_CLASSES = digit_recognizer_pkg::NUM_CLASSES,
  parameter int PIXEL_W     = digit_recognizer_pkg::PIXEL_W
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        SCK,
  input  logic        SS,
  input  logic        MOSI,
  output logic        MISO,
  inout  wire  [15:0] data,
  output logic [15:0] address,
  output logic        ce,
  output logic        oe,
  output logic        we
);
  import digit_recognizer_pkg::*;

  // state      | meaning
  // ST_IDLE    | after reset, waiting for a load command
  // ST_LOAD    | receiving packed pixel bytes
  // ST_LOADED  | image complete, waiting for run
  // ST_COMPUTE | reading weights and accumulating class scores
  // ST_DONE    | digit and ready valid

  localparam int PIX_AW = $clog2(NUM_PIXELS);
  localparam int LD_AW  = $clog2(NUM_PIXELS / 2);
  localparam int CLS_AW = $clog2(NUM_CLASSES);
  localparam int PROD_W = PIXEL_W + 17;
  localparam logic [15:0]       BIAS_ADDR = 16'(NUM_CLASSES * NUM_PIXELS);
  localparam logic [LD_AW-1:0]  LD_LAST   = LD_AW'(NUM_PIXELS / 2 - 1);
  localparam logic [PIX_AW-1:0] PIX_LAST  = PIX_AW'(NUM_PIXELS - 1);
  localparam logic [CLS_AW-1:0] CLS_LAST  = CLS_AW'(NUM_CLASSES - 1);
`ifdef SCORE_BIAS_EN
  localparam logic BIAS_EN = 1'b1;
`else
  localparam logic BIAS_EN = 1'b0;
`endif

  state_e state_q, state_d;
  logic start_load, start_run, class_done;

  logic              rx_valid;
  logic [7:0]        rx_byte, status;
  logic [PIXEL_W-1:0] pix_buf [NUM_PIXELS];
  logic [LD_AW-1:0]  load_idx;
  logic [PIX_AW-1:0] pix_idx;
  logic [CLS_AW-1:0] class_idx, best_class, best_class_next;
  logic [15:0]       class_base, rd_addr;
  logic              rd_phase, bias_pend, best_upd;
  logic signed [31:0] score, best_score, score_next;
  logic signed [PROD_W-1:0] pix_ext, wt_ext, prod;
  logic [3:0]        digit;
  logic              ready;

  assign status = {ready, 3'b000, digit};
  assign data   = {16{1'bz}};
  assign we     = 1'b1;

  spi_byte_slave u_spi (
    .clk      (clk),
    .n_rst    (n_rst),
    .sck      (SCK),
    .ss       (SS),
    .mosi     (MOSI),
    .status   (status),
    .miso     (MISO),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte)
  );

  always_comb begin
    pix_ext         = PROD_W'($signed({1'b0, pix_buf[pix_idx]}));
    wt_ext          = PROD_W'($signed(data));
    prod            = pix_ext * wt_ext;
    score_next      = score + 32'(prod);
    best_upd        = (class_idx == '0) || (score_next > best_score);
    best_class_next = best_upd ? class_idx : best_class;
    rd_addr         = bias_pend ? (BIAS_ADDR + 16'(class_idx)) : (class_base + 16'(pix_idx));
    class_done      = (state_q == ST_COMPUTE) && rd_phase && !bias_pend && (pix_idx == PIX_LAST);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    start_load = 1'b0;
    start_run  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (rx_valid && rx_byte == CMD_LOAD) begin
          state_d    = ST_LOAD;
          start_load = 1'b1;
        end
      end
      ST_LOAD: begin
        if (rx_valid && load_idx == LD_LAST) state_d = ST_LOADED;
      end
      ST_LOADED: begin
        if (rx_valid && rx_byte == CMD_LOAD) begin
          state_d    = ST_LOAD;
          start_load = 1'b1;
        end else if (rx_valid && rx_byte == CMD_RUN) begin
          state_d   = ST_COMPUTE;
          start_run = 1'b1;
        end
      end
      ST_COMPUTE: begin
        if (rx_valid && rx_byte == CMD_LOAD) begin
          state_d    = ST_LOAD;
          start_load = 1'b1;
        end else if (class_done && class_idx == CLS_LAST) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Each weight read: address/ce/oe registered in phase 0, data captured in phase 1.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_PIXELS; i++) pix_buf[i] <= '0;
      load_idx   <= '0;
      pix_idx    <= '0;
      class_idx  <= '0;
      class_base <= '0;
      rd_phase   <= 1'b0;
      bias_pend  <= 1'b0;
      score      <= '0;
      best_score <= '0;
      best_class <= '0;
      digit      <= '0;
      ready      <= 1'b0;
      address    <= '0;
      ce         <= 1'b1;
      oe         <= 1'b1;
    end else begin
      if (state_q == ST_LOAD && rx_valid) begin
        pix_buf[{load_idx, 1'b0}] <= PIXEL_W'(rx_byte[3:0]);
        pix_buf[{load_idx, 1'b1}] <= PIXEL_W'(rx_byte[7:4]);
        load_idx <= load_idx + 1'b1;
      end
      if (start_load) begin
        ready    <= 1'b0;
        load_idx <= '0;
        ce       <= 1'b1;
        oe       <= 1'b1;
        rd_phase <= 1'b0;
      end
      if (start_run) begin
        class_idx  <= '0;
        pix_idx    <= '0;
        class_base <= '0;
        rd_phase   <= 1'b0;
        bias_pend  <= BIAS_EN;
        score      <= '0;
        best_score <= '0;
        best_class <= '0;
      end
      if (state_q == ST_COMPUTE && !start_load) begin
        if (!rd_phase) begin
          address  <= rd_addr;
          ce       <= 1'b0;
          oe       <= 1'b0;
          rd_phase <= 1'b1;
        end else begin
          ce       <= 1'b1;
          oe       <= 1'b1;
          rd_phase <= 1'b0;
          if (bias_pend) begin
            score     <= 32'($signed(data));
            bias_pend <= 1'b0;
          end else if (pix_idx == PIX_LAST) begin
            if (best_upd) best_score <= score_next;
            best_class <= best_class_next;
            score      <= '0;
            pix_idx    <= '0;
            class_idx  <= class_idx + 1'b1;
            class_base <= class_base + 16'(NUM_PIXELS);
            bias_pend  <= BIAS_EN;
            if (class_idx == CLS_LAST) begin
              digit <= 4'(best_class_next);
              ready <= 1'b1;
            end
          end else begin
            score   <= score_next;
            pix_idx <= pix_idx + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_digit_recognizer.sv
// Bench for digit_recognizer: SPI master, flash model and a plain-arithmetic
// classifier reference; honours SCORE_BIAS_EN when defined.
module tb_digit_recognizer;

  localparam int NP = 144;
  localparam int NC = 10;
  localparam int BIAS_ADDR = NP * NC;
`ifdef SCORE_BIAS_EN
  localparam int RD_PER_CLS = NP + 1;
`else
  localparam int RD_PER_CLS = NP;
`endif

  logic        clk = 1'b0;
  logic        n_rst, SCK, SS, MOSI;
  wire         MISO;
  wire  [15:0] data;
  wire  [15:0] address;
  wire         ce, oe, we;

  logic [15:0] flash [0:2047];
  logic [3:0]  img [NP];

  int   n_chk = 0, n_pass = 0;
  logic computing = 1'b0;
  logic comp_d = 1'b0;
  logic prev_ce = 1'b1;
  logic [15:0] prev_addr = '0;
  int   ce_bad = 0, we_bad = 0, n_reads = 0, cyc = 0, first_rd = -1, last_rd = -1;

  digit_recognizer dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .SCK     (SCK),
    .SS      (SS),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .data    (data),
    .address (address),
    .ce      (ce),
    .oe      (oe),
    .we      (we)
  );

  assign data = (!ce && !oe) ? flash[address[10:0]] : 16'hzzzz;

  always #5 clk = ~clk;

  // Bus watcher: counts distinct reads per run and flags illegal strobes.
  always @(negedge clk) begin
    cyc    <= cyc + 1;
    comp_d <= computing;
    if (computing && !comp_d) begin
      n_reads  <= 0;
      first_rd <= -1;
    end else if (!ce && (prev_ce || address != prev_addr)) begin
      n_reads <= n_reads + 1;
      if (first_rd < 0) first_rd <= cyc;
      last_rd <= cyc;
    end
    prev_ce   <= ce;
    prev_addr <= address;
    if (we !== 1'b1) we_bad <= we_bad + 1;
    if ((!ce || !oe) && !computing) ce_bad <= ce_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
    SS = 1'b0;
    #100;
    for (int i = 0; i < 8; i++) begin
      MOSI = tx[i];
      #50;
      rx[i] = MISO;
      SCK = 1'b1;
      #50;
      SCK = 1'b0;
    end
    #60;
    SS = 1'b1;
    #100;
  endtask

  task automatic send_pixels();
    logic [7:0] r;
    for (int k = 0; k < NP / 2; k++) spi_xfer({img[2*k+1], img[2*k]}, r);
  endtask

  task automatic send_image();
    logic [7:0] r;
    spi_xfer(8'h00, r);
    send_pixels();
  endtask

  task automatic run_check(input string tag, input logic [7:0] expv, input bit mid_poll);
    logic [7:0] r;
    computing = 1'b1;
    spi_xfer(8'hFF, r);
    chk({tag, "_pre_ready"}, 32'(r[7]), 32'd0);
    if (mid_poll) begin
      spi_xfer(8'hFF, r);
      chk({tag, "_busy_ready"}, 32'(r[7]), 32'd0);
    end
    #31000;
    spi_xfer(8'hFF, r);
    chk({tag, "_status"}, 32'(r), 32'(expv));
    chk({tag, "_reads"}, n_reads, NC * RD_PER_CLS);
    chk({tag, "_within_3000"}, 32'(last_rd - first_rd < 3000), 32'd1);
    computing = 1'b0;
  endtask

  function automatic logic [7:0] predict();
    longint s, best;
    int bc;
    best = 0;
    bc   = 0;
    for (int c = 0; c < NC; c++) begin
      s = 0;
`ifdef SCORE_BIAS_EN
      s = longint'($signed(flash[BIAS_ADDR + c]));
`endif
      for (int p = 0; p < NP; p++)
        s += longint'(img[p]) * longint'($signed(flash[c * NP + p]));
      if (c == 0 || s > best) begin
        best = s;
        bc   = c;
      end
    end
    return {1'b1, 3'b000, 4'(bc)};
  endfunction

  task automatic clear_flash();
    for (int i = 0; i < 2048; i++) flash[i] = 16'h0000;
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] expv;
    n_rst = 1'b0;
    SS    = 1'b1;
    SCK   = 1'b0;
    MOSI  = 1'b0;
    clear_flash();
    #100;
    chk("rst_miso", 32'(MISO), 32'd0);
    chk("rst_ce", 32'(ce), 32'd1);
    chk("rst_oe", 32'(oe), 32'd1);
    chk("rst_we", 32'(we), 32'd1);
    chk("rst_address", 32'(address), 32'd0);
    n_rst = 1'b1;
    #100;

    // class 3 weights +1, image all ones
    for (int i = 0; i < NP; i++) begin
      flash[3 * NP + i] = 16'd1;
      img[i] = 4'd1;
    end
    send_image();
    run_check("cls3", 8'h83, 1'b0);

    // all-zero weights tie, pixels 1,2,3,4 repeating, poll while busy
    clear_flash();
    for (int i = 0; i < NP; i++) img[i] = 4'((i % 4) + 1);
    send_image();
    run_check("tie", 8'h80, 1'b1);

    // class 7 at -1, class 5 at +2, saturated image
    for (int i = 0; i < NP; i++) begin
      flash[7 * NP + i] = 16'hFFFF;
      flash[5 * NP + i] = 16'd2;
      img[i] = 4'hF;
    end
    send_image();
    run_check("cls5", 8'h85, 1'b0);

    // reset in the middle of a load, then a full reload with random data
    for (int i = 0; i < 2048; i++) flash[i] = 16'($urandom);
    spi_xfer(8'h00, r);
    for (int k = 0; k < 40; k++) spi_xfer(8'($urandom), r);
    n_rst = 1'b0;
    #50;
    chk("midrst_address", 32'(address), 32'd0);
    chk("midrst_ce", 32'(ce), 32'd1);
    chk("midrst_oe", 32'(oe), 32'd1);
    chk("midrst_miso", 32'(MISO), 32'd0);
    n_rst = 1'b1;
    #100;
    spi_xfer(8'hFF, r);
    chk("midrst_status", 32'(r), 32'h00);
    for (int i = 0; i < NP; i++) img[i] = 4'($urandom);
    expv = predict();
    send_image();
    run_check("reload", expv, 1'b0);

    // random run aborted by a load command, then a fresh image and run
    for (int i = 0; i < 2048; i++) flash[i] = 16'($urandom);
    for (int i = 0; i < NP; i++) img[i] = 4'($urandom);
    send_image();
    computing = 1'b1;
    spi_xfer(8'hFF, r);
    #5000;
    spi_xfer(8'h00, r);
    chk("abort_ready", 32'(r[7]), 32'd0);
    #200;
    computing = 1'b0;
    for (int i = 0; i < NP; i++) img[i] = 4'($urandom);
    expv = predict();
    send_pixels();
    run_check("after_abort", expv, 1'b0);

    chk("we_always_high", we_bad, 0);
    chk("ce_oe_only_compute", ce_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
